mem_stage: RTL and testbench

- Memory-access pipeline stage of the RV64 core; sits between execute and write-back.
- Accepts one instruction from execute over a valid/ready handshake.
- Performs at most one data-memory transaction per instruction over a request/response port, sign/zero-formats loads.
- Drives mem_to_wb_bus, which write-back registers unconditionally every cycle; a bubble is rf_we=0.

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_lsu_fmt.sv | 66 ++++++
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, size codes and FSM encoding for mem_stage
package mem_stage_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int MEM_TO_WB_WD   = 2 * XLEN_DEF + 1 + REG_ADDR_W_DEF;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        logic mis;
        case (size)
            SIZE_H:  mis = a[0];
            SIZE_W:  mis = |a[1:0];
            SIZE_D:  mis = |a;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// rtl/mem_lsu_fmt.sv - combinational store lane/mask builder and load extract/extend
module mem_lsu_fmt
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [1:0]      size,
    input  logic [2:0]      addr_lo,
    input  logic            load_unsigned,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [2:0]      lane;
    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic            sign;

    always_comb begin
        lane      = addr_lo;
        wmask     = 8'h00;
        load_data = '0;
        sign      = 1'b0;
        // Low address bits below the access size are dropped, so lanes stay naturally aligned.
        case (size)
            SIZE_B: begin
                lane  = addr_lo;
                wmask = 8'h01 << lane;
            end
            SIZE_H: begin
                lane  = {addr_lo[2:1], 1'b0};
                wmask = 8'h03 << lane;
            end
            SIZE_W: begin
                lane  = {addr_lo[2], 2'b00};
                wmask = 8'h0F << lane;
            end
            default: begin
                lane  = 3'd0;
                wmask = 8'hFF;
            end
        endcase
        shamt   = {lane, 3'b000};
        wdata   = store_data << shamt;
        shifted = rdata >> shamt;
        case (size)
            SIZE_B: begin
                sign      = ~load_unsigned & shifted[7];
                load_data = {{(XLEN-8){sign}}, shifted[7:0]};
            end
            SIZE_H: begin
                sign      = ~load_unsigned & shifted[15];
                load_data = {{(XLEN-16){sign}}, shifted[15:0]};
            end
            SIZE_W: begin
                sign      = ~load_unsigned & shifted[31];
                load_data = {{(XLEN-32){sign}}, shifted[31:0]};
            end
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV64 memory-access stage, IDLE/REQ/WAIT data-memory sequencer
// Optional misaligned-access trap: define MEM_STAGE_MISALIGN_CHK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ex_valid,
    output logic                           ex_ready,
    input  logic [XLEN-1:0]                ex_pc,
    input  logic                           ex_rf_we,
    input  logic [REG_ADDR_W-1:0]          ex_rf_waddr,
    input  logic [XLEN-1:0]                ex_alu_result,
    input  logic [XLEN-1:0]                ex_store_data,
    input  logic                           ex_mem_re,
    input  logic                           ex_mem_we,
    input  logic [1:0]                     ex_mem_size,
    input  logic                           ex_load_unsigned,
    output logic                           dmem_req_valid,
    input  logic                           dmem_req_ready,
    output logic [XLEN-1:0]                dmem_req_addr,
    output logic                           dmem_req_we,
    output logic [XLEN-1:0]                dmem_req_wdata,
    output logic [7:0]                     dmem_req_wmask,
    input  logic                           dmem_resp_valid,
    input  logic [XLEN-1:0]                dmem_resp_rdata,
    output logic [2*XLEN+1+REG_ADDR_W-1:0] mem_to_wb_bus,
    output logic                           misalign_exc
);

    state_e state, state_n;

    logic [XLEN-1:0]       cap_pc;
    logic                  cap_rf_we;
    logic [REG_ADDR_W-1:0] cap_waddr;
    logic [XLEN-1:0]       cap_addr;
    logic [XLEN-1:0]       cap_store_data;
    logic                  cap_we;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;

    logic [2*XLEN+1+REG_ADDR_W-1:0] bus_q;
    logic                           exc_q;

    logic            accept;
    logic            is_mem;
    logic            mis;
    logic            in_req;
    logic [7:0]      fmt_wmask;
    logic [XLEN-1:0] fmt_wdata;
    logic [XLEN-1:0] fmt_load;

    assign ex_ready = (state == S_IDLE);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_mem_re || ex_mem_we;
    assign in_req   = (state == S_REQ);

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    assign mis = is_misaligned(ex_mem_size, ex_alu_result[2:0]);
`else
    assign mis = 1'b0;
`endif

    mem_lsu_fmt #(.XLEN(XLEN)) u_fmt (
        .size          (cap_size),
        .addr_lo       (cap_addr[2:0]),
        .load_unsigned (cap_unsigned),
        .store_data    (cap_store_data),
        .rdata         (dmem_resp_rdata),
        .wmask         (fmt_wmask),
        .wdata         (fmt_wdata),
        .load_data     (fmt_load)
    );

    // Request fields are zero outside REQ so nothing leaks while idle or waiting.
    assign dmem_req_valid = in_req;
    assign dmem_req_addr  = in_req ? {cap_addr[XLEN-1:3], 3'b000} : '0;
    assign dmem_req_we    = in_req && cap_we;
    assign dmem_req_wdata = (in_req && cap_we) ? fmt_wdata : '0;
    assign dmem_req_wmask = (in_req && cap_we) ? fmt_wmask : 8'h00;
    assign mem_to_wb_bus  = bus_q;
    assign misalign_exc   = exc_q;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept && is_mem && !mis) state_n = S_REQ;
            S_REQ:   if (dmem_req_ready) state_n = S_WAIT;
            S_WAIT:  if (dmem_resp_valid) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bus_q          <= '0;
            exc_q          <= 1'b0;
            cap_pc         <= '0;
            cap_rf_we      <= 1'b0;
            cap_waddr      <= '0;
            cap_addr       <= '0;
            cap_store_data <= '0;
            cap_we         <= 1'b0;
            cap_size       <= 2'd0;
            cap_unsigned   <= 1'b0;
        end else begin
            state <= state_n;
            bus_q <= '0;
            exc_q <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    bus_q <= {ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result};
                end else if (mis) begin
                    exc_q <= 1'b1;
                end else begin
                    cap_pc         <= ex_pc;
                    cap_rf_we      <= ex_rf_we;
                    cap_waddr      <= ex_rf_waddr;
                    cap_addr       <= ex_alu_result;
                    cap_store_data <= ex_store_data;
                    cap_we         <= ex_mem_we;
                    cap_size       <= ex_mem_size;
                    cap_unsigned   <= ex_load_unsigned;
                end
            end
            // Stores retire with rf_we low but keep the PC for write-back bookkeeping.
            if (state == S_WAIT && dmem_resp_valid) begin
                bus_q <= {cap_pc, cap_rf_we && !cap_we, cap_waddr,
                          cap_we ? {XLEN{1'b0}} : fmt_load};
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         ex_valid;
    logic         ex_ready;
    logic [63:0]  ex_pc;
    logic         ex_rf_we;
    logic [4:0]   ex_rf_waddr;
    logic [63:0]  ex_alu_result;
    logic [63:0]  ex_store_data;
    logic         ex_mem_re;
    logic         ex_mem_we;
    logic [1:0]   ex_mem_size;
    logic         ex_load_unsigned;
    logic         dmem_req_valid;
    logic         dmem_req_ready;
    logic [63:0]  dmem_req_addr;
    logic         dmem_req_we;
    logic [63:0]  dmem_req_wdata;
    logic [7:0]   dmem_req_wmask;
    logic         dmem_resp_valid;
    logic [63:0]  dmem_resp_rdata;
    logic [133:0] mem_to_wb_bus;
    logic         misalign_exc;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] LD_PC = 64'h0000_0000_8000_0100;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_pc            (ex_pc),
        .ex_rf_we         (ex_rf_we),
        .ex_rf_waddr      (ex_rf_waddr),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_mem_re        (ex_mem_re),
        .ex_mem_we        (ex_mem_we),
        .ex_mem_size      (ex_mem_size),
        .ex_load_unsigned (ex_load_unsigned),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_we      (dmem_req_we),
        .dmem_req_wdata   (dmem_req_wdata),
        .dmem_req_wmask   (dmem_req_wmask),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_resp_rdata  (dmem_resp_rdata),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .misalign_exc     (misalign_exc)
    );

    task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic [63:0] addr, input logic [1:0] size, input logic we,
                             input logic uns, input logic [63:0] sdata);
        ex_valid         = 1'b1;
        ex_pc            = LD_PC;
        ex_rf_we         = 1'b1;
        ex_rf_waddr      = 5'd7;
        ex_alu_result    = addr;
        ex_store_data    = sdata;
        ex_mem_re        = ~we;
        ex_mem_we        = we;
        ex_mem_size      = size;
        ex_load_unsigned = uns;
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
        drive_mem(addr, size, 1'b0, uns, 64'h0);
        tick();
        ex_valid = 1'b0;
        chk({tag, "_req_valid"}, dmem_req_valid, 1'b1);
        chk({tag, "_req_addr"}, dmem_req_addr, {addr[63:3], 3'b000});
        chk({tag, "_req_wmask"}, dmem_req_wmask, 8'h00);
        chk({tag, "_bubble"}, mem_to_wb_bus, 134'h0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        tick();
        dmem_resp_valid = 1'b0;
        chk({tag, "_result"}, mem_to_wb_bus, {LD_PC, 1'b1, 5'd7, exp});
        tick();
        chk({tag, "_after"}, mem_to_wb_bus, 134'h0);
    endtask

    task automatic do_store(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] sdata, input logic [7:0] exp_mask,
                            input logic [63:0] exp_wdata, input int stall, input int resp_delay);
        drive_mem(addr, size, 1'b1, 1'b0, sdata);
        tick();
        for (int i = 0; i <= stall; i++) begin
            chk({tag, "_req_valid"}, dmem_req_valid, 1'b1);
            chk({tag, "_req_we"}, dmem_req_we, 1'b1);
            chk({tag, "_req_addr"}, dmem_req_addr, {addr[63:3], 3'b000});
            chk({tag, "_req_wmask"}, dmem_req_wmask, exp_mask);
            chk({tag, "_req_wdata"}, dmem_req_wdata, exp_wdata);
            chk({tag, "_ex_ready"}, ex_ready, 1'b0);
            if (i == stall) dmem_req_ready = 1'b1;
            tick();
        end
        dmem_req_ready = 1'b0;
        for (int i = 1; i < resp_delay; i++) begin
            chk({tag, "_wait_ready"}, ex_ready, 1'b0);
            chk({tag, "_wait_bus"}, mem_to_wb_bus, 134'h0);
            chk({tag, "_wait_req"}, dmem_req_valid, 1'b0);
            tick();
        end
        ex_valid        = 1'b0;
        dmem_resp_valid = 1'b1;
        tick();
        dmem_resp_valid = 1'b0;
        chk({tag, "_ack"}, mem_to_wb_bus, {LD_PC, 1'b0, 5'd7, 64'h0});
        tick();
        chk({tag, "_single"}, mem_to_wb_bus, 134'h0);
    endtask

    initial begin
        rst              = 1'b1;
        ex_valid         = 1'b0;
        ex_pc            = '0;
        ex_rf_we         = 1'b0;
        ex_rf_waddr      = '0;
        ex_alu_result    = '0;
        ex_store_data    = '0;
        ex_mem_re        = 1'b0;
        ex_mem_we        = 1'b0;
        ex_mem_size      = 2'd0;
        ex_load_unsigned = 1'b0;
        dmem_req_ready   = 1'b0;
        dmem_resp_valid  = 1'b0;
        dmem_resp_rdata  = '0;
        tick();
        tick();
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_bus", mem_to_wb_bus, 134'h0);
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_req_addr", dmem_req_addr, 64'h0);
        chk("rst_misalign", misalign_exc, 1'b0);
        rst = 1'b0;
        tick();

        ex_valid      = 1'b1;
        ex_pc         = 64'h0000_0000_8000_0000;
        ex_rf_we      = 1'b1;
        ex_rf_waddr   = 5'd5;
        ex_alu_result = 64'h1234;
        tick();
        ex_valid = 1'b0;
        chk("alu_bus", mem_to_wb_bus, {64'h0000_0000_8000_0000, 1'b1, 5'd5, 64'h1234});
        chk("alu_ready", ex_ready, 1'b1);
        chk("alu_no_req", dmem_req_valid, 1'b0);
        tick();
        chk("alu_bubble", mem_to_wb_bus, 134'h0);

        do_load("lb_ff",  64'h8000_1002, 2'd0, 1'b0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        do_load("lbu_ff", 64'h8000_1002, 2'd0, 1'b1, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_00FF);
        do_load("lb_80",  64'h8000_1003, 2'd0, 1'b0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lh_neg", 64'h8000_1006, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lwu",    64'h8000_1004, 2'd2, 1'b1, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
        do_load("lw",     64'h8000_1004, 2'd2, 1'b0, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
        do_load("ld",     64'h8000_1008, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        do_store("sh", 64'h8000_1006, 2'd1, 64'h0000_0000_0000_ABCD, 8'hC0, 64'hABCD_0000_0000_0000, 0, 1);
        do_store("sb", 64'h8000_1005, 2'd0, 64'h0000_0000_0000_0077, 8'h20, 64'h0000_7700_0000_0000, 0, 1);
        do_store("sd_stall", 64'h8000_1010, 2'd3, 64'h1122_3344_5566_7788, 8'hFF,
                 64'h1122_3344_5566_7788, 4, 3);

        drive_mem(64'h8000_1000, 2'd3, 1'b0, 1'b0, 64'h0);
        tick();
        ex_valid       = 1'b0;
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("rstw_in_wait", ex_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst             = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        dmem_resp_valid = 1'b0;
        chk("rstw_idle", ex_ready, 1'b1);
        chk("rstw_bus", mem_to_wb_bus, 134'h0);
        tick();
        chk("rstw_bus2", mem_to_wb_bus, 134'h0);
        chk("rstw_no_req", dmem_req_valid, 1'b0);

`ifdef MEM_STAGE_MISALIGN_CHK_EN
        drive_mem(64'h8000_1002, 2'd2, 1'b0, 1'b0, 64'h0);
        tick();
        ex_valid = 1'b0;
        chk("mis_exc", misalign_exc, 1'b1);
        chk("mis_no_req", dmem_req_valid, 1'b0);
        chk("mis_bus", mem_to_wb_bus, 134'h0);
        chk("mis_ready", ex_ready, 1'b1);
        tick();
        chk("mis_pulse_end", misalign_exc, 1'b0);
        chk("mis_no_req2", dmem_req_valid, 1'b0);
`else
        do_load("lw_trunc", 64'h8000_1002, 2'd2, 1'b1, 64'h0000_0000_CAFE_F00D, 64'h0000_0000_CAFE_F00D);
        chk("mis_tied", misalign_exc, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
